// File: rtl/column_select_input_if.sv
// Column-select bundle between the player button front end and the board FSM.
interface column_select_input_if;
    logic [3:0] btn_n;        // raw active-low column buttons
    logic [1:0] game_status;  // 00 = in play
    logic [3:0] in_column;    // accepted column, active-low one-hot
    logic       enable;       // one-cycle strobe qualifying in_column
    logic       press_error;  // one-cycle pulse on a multi-button press
    logic       locked;       // presses blocked by game status

    // Player/board side: drives buttons and status, observes the result.
    modport master (
        output btn_n,
        output game_status,
        input  in_column,
        input  enable,
        input  press_error,
        input  locked
    );

    // Front end itself.
    modport slave (
        input  btn_n,
        input  game_status,
        output in_column,
        output enable,
        output press_error,
        output locked
    );
endinterface

// File: rtl/column_select_input.sv
// Connect4 column-select front end: synchronizes and debounces four active-low
// column buttons and turns each physical press into one enable strobe.
module column_select_input #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    column_select_input_if.slave   bus
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitRel = 2'd1,
        StLocked  = 2'd2
    } state_e;

    logic [3:0]       s1_q, s2_q, s3_q;
    logic [CNT_W-1:0] cnt_q;
    state_e           state_q, state_d;
    logic [3:0]       in_column_q, in_column_d;
    logic             enable_q, enable_d;
    logic             press_error_q, press_error_d;

    logic [3:0] stable;
    logic [3:0] pressed;
    logic       stable_valid;
    logic       one_pressed;
    logic       multi_pressed;
    logic       all_released;
    logic       game_over;

    // Two-flop synchronizer, then a third stage compared against s2 for debounce.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q  <= 4'hF;
            s2_q  <= 4'hF;
            s3_q  <= 4'hF;
            cnt_q <= '0;
        end else begin
            s1_q <= bus.btn_n;
            s2_q <= s1_q;
            s3_q <= s2_q;
            if (s2_q != s3_q) begin
                cnt_q <= '0;
            end else if (cnt_q != CntMax) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Decode the debounced vector.
    always_comb begin
        stable        = s3_q;
        stable_valid  = (cnt_q == CntMax);
        pressed       = ~s3_q;
        // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
        one_pressed   = (pressed != 4'h0) && ((pressed & (pressed - 4'd1)) == 4'h0);
        multi_pressed = (pressed != 4'h0) && !one_pressed;
        all_released  = (s3_q == 4'hF);
        game_over     = (bus.game_status != 2'b00);
    end

    // State and registered outputs; reset lands in WAIT_REL so a held button is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StWaitRel;
            in_column_q   <= 4'hF;
            enable_q      <= 1'b0;
            press_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_column_q   <= in_column_d;
            enable_q      <= enable_d;
            press_error_q <= press_error_d;
        end
    end

    // Next-state logic; strobes are only raised on leaving IDLE, so they never repeat.
    always_comb begin
        state_d       = state_q;
        in_column_d   = in_column_q;
        enable_d      = 1'b0;
        press_error_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Lock check wins over a press landing in the same cycle.
                if (game_over) begin
                    state_d = StLocked;
                end else if (stable_valid && one_pressed) begin
                    in_column_d = stable;
                    enable_d    = 1'b1;
                    state_d     = StWaitRel;
                end else if (stable_valid && multi_pressed) begin
                    press_error_d = 1'b1;
                    state_d       = StWaitRel;
                end
            end
            StWaitRel: begin
                if (stable_valid && all_released) begin
                    state_d = game_over ? StLocked : StIdle;
                end
            end
            StLocked: begin
                if (!game_over && stable_valid && all_released) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StWaitRel;
        endcase
    end

    // Drive the bundle.
    always_comb begin
        bus.in_column   = in_column_q;
        bus.enable      = enable_q;
        bus.press_error = press_error_q;
        bus.locked      = (state_q == StLocked);
    end

endmodule

// File: tb/tb_column_select_input.sv
// Directed bench for column_select_input with DEBOUNCE_CYCLES=4.
module tb_column_select_input;

    logic clk;
    logic reset;

    column_select_input_if u_if ();

    column_select_input #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    // Pulse bookkeeping sampled on the falling edge.
    int         en_cnt;
    int         err_cnt;
    int         both_viol;
    int         consec_viol;
    int         col_viol;
    logic       prev_en;
    logic [3:0] prev_col;
    logic [3:0] last_col;

    initial begin
        en_cnt      = 0;
        err_cnt     = 0;
        both_viol   = 0;
        consec_viol = 0;
        col_viol    = 0;
        prev_en     = 1'b0;
        prev_col    = 4'hF;
        last_col    = 4'hF;
    end

    // Count strobes and watch the output invariants.
    always @(negedge clk) begin
        if (reset) begin
            if (u_if.enable) begin
                en_cnt++;
                last_col = u_if.in_column;
            end
            if (u_if.press_error) err_cnt++;
            if (u_if.enable && u_if.press_error) both_viol++;
            if (u_if.enable && prev_en) consec_viol++;
            if ((u_if.in_column != prev_col) && !u_if.enable) col_viol++;
        end
        prev_en  = u_if.enable;
        prev_col = u_if.in_column;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles; lands just after a falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Edge index (0-based from the next rising edge) of the first enable, or -1.
    task automatic first_enable(input int budget, output int first);
        first = -1;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (u_if.enable && first < 0) first = i;
        end
    endtask

    task automatic press(input logic [3:0] v, input int hold, input int rel);
        u_if.btn_n = v;
        tick(hold);
        u_if.btn_n = 4'hF;
        tick(rel);
    endtask

    int         first;
    int         en0;
    int         err0;
    logic [3:0] seq [4];

    initial begin
        n_tests            = 0;
        n_fail             = 0;
        reset              = 1'b0;
        u_if.btn_n         = 4'hF;
        u_if.game_status   = 2'b00;
        tick(3);
        check("rst_in_column", 32'(u_if.in_column), 32'hF);
        check("rst_enable", 32'(u_if.enable), 32'h0);
        check("rst_press_error", 32'(u_if.press_error), 32'h0);
        check("rst_locked", 32'(u_if.locked), 32'h0);
        reset = 1'b1;
        tick(12);

        // 1. single press, exact latency, column held after release
        en0        = en_cnt;
        u_if.btn_n = 4'b1110;
        first_enable(20, first);
        check("t1_latency", 32'(first), 32'd7);
        check("t1_in_column", 32'(u_if.in_column), 32'hE);
        u_if.btn_n = 4'hF;
        tick(12);
        check("t1_held_col", 32'(u_if.in_column), 32'hE);
        check("t1_pulses", 32'(en_cnt - en0), 32'd1);

        // 2. bouncing press collapses into one strobe after the final edge
        en0 = en_cnt;
        for (int k = 0; k < 6; k++) begin
            u_if.btn_n = (k % 2 == 0) ? 4'b1101 : 4'b1111;
            tick(2);
        end
        check("t2_no_early", 32'(en_cnt - en0), 32'd0);
        u_if.btn_n = 4'b1101;
        first_enable(20, first);
        check("t2_latency", 32'(first), 32'd7);
        check("t2_in_column", 32'(u_if.in_column), 32'hD);
        u_if.btn_n = 4'hF;
        tick(12);
        check("t2_pulses", 32'(en_cnt - en0), 32'd1);

        // 3. multi-button press gives an error, then a legal press works
        en0  = en_cnt;
        err0 = err_cnt;
        press(4'b1100, 10, 12);
        check("t3_error", 32'(err_cnt - err0), 32'd1);
        check("t3_no_enable", 32'(en_cnt - en0), 32'd0);
        check("t3_col_kept", 32'(u_if.in_column), 32'hD);
        press(4'b1011, 12, 12);
        check("t3_enable", 32'(en_cnt - en0), 32'd1);
        check("t3_col", 32'(last_col), 32'hB);

        // 4. locked while game over; held button across unlock does not fire
        en0              = en_cnt;
        u_if.game_status = 2'b01;
        tick(3);
        check("t4_locked", 32'(u_if.locked), 32'h1);
        u_if.btn_n = 4'b0111;
        tick(12);
        check("t4_no_en_locked", 32'(en_cnt - en0), 32'd0);
        u_if.game_status = 2'b00;
        tick(12);
        check("t4_no_en_unlock", 32'(en_cnt - en0), 32'd0);
        check("t4_still_locked", 32'(u_if.locked), 32'h1);
        u_if.btn_n = 4'hF;
        tick(12);
        check("t4_unlocked", 32'(u_if.locked), 32'h0);
        press(4'b0111, 12, 12);
        check("t4_enable", 32'(en_cnt - en0), 32'd1);
        check("t4_col", 32'(u_if.in_column), 32'h7);

        // 5. async reset mid-debounce, held button ignored afterwards
        en0        = en_cnt;
        u_if.btn_n = 4'b0111;
        tick(3);
        reset = 1'b0;
        #1;
        check("t5_rst_col", 32'(u_if.in_column), 32'hF);
        check("t5_rst_en", 32'(u_if.enable), 32'h0);
        tick(2);
        reset = 1'b1;
        tick(20);
        check("t5_held_ignored", 32'(en_cnt - en0), 32'd0);
        u_if.btn_n = 4'hF;
        tick(12);
        press(4'b0111, 12, 12);
        check("t5_repress", 32'(en_cnt - en0), 32'd1);
        check("t5_col", 32'(u_if.in_column), 32'h7);

        // 6. sixteen legally spaced presses across all columns
        seq[0] = 4'b1110;
        seq[1] = 4'b1101;
        seq[2] = 4'b1011;
        seq[3] = 4'b0111;
        en0    = en_cnt;
        err0   = err_cnt;
        for (int k = 0; k < 16; k++) begin
            press(seq[k % 4], 12, 12);
            check($sformatf("t6_col%0d", k), 32'(last_col), 32'(seq[k % 4]));
        end
        check("t6_pulses", 32'(en_cnt - en0), 32'd16);
        check("t6_no_error", 32'(err_cnt - err0), 32'd0);

        check("inv_en_and_err", 32'(both_viol), 32'd0);
        check("inv_en_consec", 32'(consec_viol), 32'd0);
        check("inv_col_change", 32'(col_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
